// File: rtl/psc_frame_pkg.sv
// Shared types, byte constants and CRC-8 (poly 0x07) step function for the PSC frame builder.
package psc_frame_pkg;

  localparam logic [7:0] PSC_SOP = 8'h3C;
  localparam logic [7:0] PSC_EOP = 8'hBC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOP,
    ST_STATUS,
    ST_CTRL,
    ST_ADDR,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } psc_frame_state_t;

  function automatic logic [7:0] crc8_07_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/psc_frame_builder_crc8.sv
// Running CRC-8 register; crc_upd is the CRC including the byte currently on data,
// so the caller can present the final CRC on the same edge the last byte is accepted.
module psc_crc8
  import psc_frame_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] crc_upd
);

  logic [7:0] crc_q;

  assign crc_upd = crc8_07_byte(crc_q, data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       crc_q <= 8'h00;
    else if (clear)  crc_q <= 8'h00;
    else if (enable) crc_q <= crc_upd;
  end

endmodule

// File: rtl/psc_frame_builder.sv
// Serialises one PSC trigger/status frame per accepted start onto a valid/ready byte stream.
// Optional feature: define PSC_FRAME_CRC8_EN for a real CRC-8 byte (otherwise the CRC byte is 8'h00).
//
// state     | meaning
// ST_IDLE   | no frame in flight
// ST_SOP    | presenting SOP
// ST_STATUS | presenting status (seq or 0)
// ST_CTRL   | presenting control byte
// ST_ADDR   | presenting address byte
// ST_DATA   | presenting payload byte byte_idx (MSB byte first)
// ST_CRC    | presenting CRC byte
// ST_EOP    | presenting EOP
module psc_frame_builder
  import psc_frame_pkg::*;
#(
  parameter int         DATA_BYTES = 4,
  parameter logic [7:0] CTRL_TRIG  = 8'h30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    is_trigger_state,
  input  logic [7:0]              addr,
  input  logic [8*DATA_BYTES-1:0] payload,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    busy,
  output logic                    status_byte_done
);

  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  psc_frame_state_t        state;
  logic [IDX_W-1:0]        byte_idx;
  logic [IDX_W-1:0]        next_idx;
  logic                    trig_q;
  logic [7:0]              addr_q;
  logic [8*DATA_BYTES-1:0] payload_q;
  logic [7:0]              seq;
  logic [7:0]              seq_nxt;
  logic [7:0]              crc_byte;
  logic                    hs;
  logic                    eop_hs;
  logic                    accept;

  assign hs       = out_valid && out_ready;
  assign eop_hs   = hs && (state == ST_EOP);
  // A start during the EOP handshake chains the next frame with no idle gap
  assign accept   = start && (!busy || eop_hs);
  assign seq_nxt  = (eop_hs && trig_q) ? seq + 8'd1 : seq;
  assign next_idx = byte_idx - 1'b1;

`ifdef PSC_FRAME_CRC8_EN
  logic crc_en;

  assign crc_en = hs && (state inside {ST_STATUS, ST_CTRL, ST_ADDR, ST_DATA});

  psc_crc8 u_crc8 (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (crc_en),
    .data    (out_data),
    .crc_upd (crc_byte)
  );
`else
  assign crc_byte = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      byte_idx         <= '0;
      trig_q           <= 1'b0;
      addr_q           <= 8'h00;
      payload_q        <= '0;
      seq              <= 8'h00;
      status_byte_done <= 1'b0;
      out_data         <= 8'h00;
      out_valid        <= 1'b0;
      out_sop          <= 1'b0;
      out_eop          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      seq              <= seq_nxt;
      status_byte_done <= (seq_nxt == 8'hFF);
      if (accept) begin
        state     <= ST_SOP;
        trig_q    <= is_trigger_state;
        addr_q    <= addr;
        payload_q <= payload;
        out_data  <= PSC_SOP;
        out_valid <= 1'b1;
        out_sop   <= 1'b1;
        out_eop   <= 1'b0;
        busy      <= 1'b1;
      end else if (hs) begin
        case (state)
          ST_SOP: begin
            state    <= ST_STATUS;
            out_sop  <= 1'b0;
            out_data <= trig_q ? seq : 8'h00;
          end
          ST_STATUS: begin
            state    <= ST_CTRL;
            out_data <= trig_q ? CTRL_TRIG : 8'h00;
          end
          ST_CTRL: begin
            state    <= ST_ADDR;
            out_data <= addr_q;
          end
          ST_ADDR: begin
            state    <= ST_DATA;
            byte_idx <= LAST_IDX;
            out_data <= payload_q[{LAST_IDX, 3'b000} +: 8];
          end
          ST_DATA: begin
            if (byte_idx == '0) begin
              state    <= ST_CRC;
              out_data <= crc_byte;
            end else begin
              byte_idx <= next_idx;
              out_data <= payload_q[{next_idx, 3'b000} +: 8];
            end
          end
          ST_CRC: begin
            state    <= ST_EOP;
            out_data <= PSC_EOP;
            out_eop  <= 1'b1;
          end
          default: begin
            state     <= ST_IDLE;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psc_frame_builder.sv
// Self-checking bench for psc_frame_builder: frames are predicted from a byte-list model
// and compared on every accepted byte, including backpressure hold and reset abort.
module tb_psc_frame_builder;

  localparam int DATA_BYTES = 4;
  localparam int DW = 8 * DATA_BYTES;
`ifdef PSC_FRAME_CRC8_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          is_trigger_state = 1'b0;
  logic [7:0]    addr = 8'h00;
  logic [DW-1:0] payload = '0;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid, out_sop, out_eop, busy, status_byte_done;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_seq = 8'h00;

  always #5 clk = ~clk;

  psc_frame_builder #(.DATA_BYTES(DATA_BYTES), .CTRL_TRIG(8'h30)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .is_trigger_state (is_trigger_state),
    .addr             (addr),
    .payload          (payload),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_sop          (out_sop),
    .out_eop          (out_eop),
    .busy             (busy),
    .status_byte_done (status_byte_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8, poly 0x07, init 0, MSB first
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (msg[k]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ msg[k][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: random ready
  task automatic send_frame(input bit trig, input logic [7:0] a, input logic [DW-1:0] pl,
                            input int mode, input bit chain);
    logic [7:0] body[$];
    logic [7:0] exp[$];
    int         got;
    int         cyc;
    bit         first;
    bit         r;
    logic       pv, pr, ps, pe;
    logic [7:0] pd;
    got = 0; cyc = 0; first = 1'b1;
    pv = 1'b0; pr = 1'b1; ps = 1'b0; pe = 1'b0; pd = 8'h00;
    body.push_back(trig ? model_seq : 8'h00);
    body.push_back(trig ? 8'h30 : 8'h00);
    body.push_back(a);
    for (int i = DATA_BYTES - 1; i >= 0; i--) body.push_back(pl[8*i +: 8]);
    exp.push_back(8'h3C);
    foreach (body[k]) exp.push_back(body[k]);
    exp.push_back(CRC_ON ? model_crc(body) : 8'h00);
    exp.push_back(8'hBC);
    start = 1'b1; is_trigger_state = trig; addr = a; payload = pl;
    while (got < exp.size() && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (first) begin
        chk("sop_latency", {30'd0, out_valid, out_sop}, 32'd3);
        chk("busy_on", busy, 1'b1);
        chk("status_byte_done", status_byte_done, model_seq == 8'hFF);
        first = 1'b0;
      end
      if (pv && !pr) chk("hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, ps, pe, pd});
      if (busy && !chain) start = 1'b0;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : bit'($urandom_range(0, 1));
      out_ready = r;
      if (out_valid && r) begin
        chk("byte", out_data, exp[got]);
        chk("sop_flag", out_sop, got == 0);
        chk("eop_flag", out_eop, got == exp.size() - 1);
        got++;
      end
      pv = out_valid; pr = r; ps = out_sop; pe = out_eop; pd = out_data;
    end
    if (got < exp.size()) chk("frame_timeout", got, exp.size());
    if (trig) model_seq++;
    if (!chain) begin
      start = 1'b0;
      @(negedge clk);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_flags", {out_sop, out_eop, busy, status_byte_done}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);

    // Basic trigger frame, full-rate then with alternating ready
    send_frame(1'b1, 8'h00, '0, 0, 1'b0);
    send_frame(1'b1, 8'h00, '0, 1, 1'b0);
    // Non-trigger frame leaves seq untouched
    send_frame(1'b0, 8'h5A, 32'h01020304, 0, 1'b0);
    send_frame(1'b1, 8'hA5, 32'hDEADBEEF, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_frame(bit'($urandom_range(0, 1)), 8'($urandom), DW'($urandom), 2, 1'b0);
    end

    // Reset while the 4th byte (address) is on the bus
    start = 1'b1; is_trigger_state = 1'b1; addr = 8'h77; payload = 32'h11223344;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_addr", out_data, 8'h77);
    reset = 1'b1;
    #1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", status_byte_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_seq = 8'h00;
    @(negedge clk);
    send_frame(1'b1, 8'h00, '0, 0, 1'b0);

    // Back-to-back trigger frames through a full sequence wrap
    for (int i = 0; i < 256; i++) send_frame(1'b1, 8'h00, '0, 0, 1'b1);
    send_frame(1'b1, 8'h00, '0, 0, 1'b0);
    send_frame(1'b1, 8'h3C, 32'hBCBC3C3C, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
